// File: rtl/alu_ctrl_pkg.sv
// Shared opcode constants, sequencer state encoding and opcode legality check
// for the front end of the shared 32-bit ALU.
package alu_ctrl_pkg;

   localparam logic [3:0] SEL_AND = 4'b0000;
   localparam logic [3:0] SEL_OR  = 4'b0001;
   localparam logic [3:0] SEL_XOR = 4'b0010;
   localparam logic [3:0] SEL_ADD = 4'b0110;
   localparam logic [3:0] SEL_SUB = 4'b0111;
   localparam logic [3:0] SEL_MUL = 4'b1001;
   localparam logic [3:0] SEL_SLL = 4'b1010;
   localparam logic [3:0] SEL_SRL = 4'b1011;
   localparam logic [3:0] SEL_SRA = 4'b1101;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_MUL,
      ST_RESP
   } state_e;

   // The two top codes have no ALU function and no sequencer emulation.
   function automatic logic is_legal_sel(input logic [3:0] sel);
      return (sel != 4'b1110) && (sel != 4'b1111);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; a contested request goes to the requester
// that did not win the previous accept.
module rr_arb2 #(
   parameter bit FIRST_PRIO = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic valid0,
   input  logic valid1,
   input  logic advance,
   output logic grant0,
   output logic grant1
);

   logic last_q;

   assign grant0 = valid0 & (~valid1 | last_q);
   assign grant1 = valid1 & (~valid0 | ~last_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= ~FIRST_PRIO;
      end else if (advance) begin
         last_q <= grant1;
      end
   end

endmodule

// File: rtl/alu_rr_sequencer.sv
// Round-robin front end for the shared ALU: registers the granted op, runs it
// for one cycle (or a shift-add loop for MUL) and returns a one-cycle response.
module alu_rr_sequencer
   import alu_ctrl_pkg::*;
#(
   parameter bit MUL_EARLY_EXIT = 1'b1,
   parameter bit FIRST_PRIO     = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_A,
   input  logic [31:0] req0_B,
   input  logic [3:0]  req0_sel,
   input  logic        req0_Cin,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_A,
   input  logic [31:0] req1_B,
   input  logic [3:0]  req1_sel,
   input  logic        req1_Cin,
   output logic        resp_valid,
   output logic        resp_id,
   output logic [31:0] resp_Y,
   output logic        resp_Cout,
   output logic        resp_Negative,
   output logic        resp_Zero,
   output logic        resp_Overflow,
   output logic        resp_err,
   output logic        busy,
   output logic [31:0] alu_A,
   output logic [31:0] alu_B,
   output logic [3:0]  alu_sel,
   output logic        alu_Cin,
   input  logic [31:0] alu_Y,
   input  logic        alu_Cout,
   input  logic        alu_Negative,
   input  logic        alu_Zero,
   input  logic        alu_Overflow
);

   state_e      state_q;
   logic [31:0] a_q, b_q, acc_q;
   logic [3:0]  sel_q;
   logic        cin_q, id_q;
   logic [4:0]  cnt_q;

   logic        grant0, grant1, idle, accept;
   logic [31:0] g_a, g_b, acc_d;
   logic [3:0]  g_sel;
   logic        g_cin, mul_done;

   assign idle       = (state_q == ST_IDLE);
   assign busy       = ~idle;
   assign req0_ready = idle & grant0;
   assign req1_ready = idle & grant1;
   assign accept     = req0_ready | req1_ready;

   rr_arb2 #(.FIRST_PRIO(FIRST_PRIO)) u_arb (
      .clk    (clk),
      .rst    (rst),
      .valid0 (req0_valid),
      .valid1 (req1_valid),
      .advance(accept),
      .grant0 (grant0),
      .grant1 (grant1)
   );

   assign g_a   = grant1 ? req1_A   : req0_A;
   assign g_b   = grant1 ? req1_B   : req0_B;
   assign g_sel = grant1 ? req1_sel : req0_sel;
   assign g_cin = grant1 ? req1_Cin : req0_Cin;

   // During MUL, a_q is the shifted multiplicand and b_q the shifted multiplier.
   assign acc_d    = b_q[0] ? alu_Y : acc_q;
   assign mul_done = (cnt_q == 5'd31) || (MUL_EARLY_EXIT && (b_q[31:1] == 31'd0));

   always_comb begin
      alu_A   = '0;
      alu_B   = '0;
      alu_sel = '0;
      alu_Cin = 1'b0;
      case (state_q)
         ST_EXEC: begin
            alu_A   = a_q;
            alu_B   = b_q;
            alu_sel = sel_q;
            alu_Cin = cin_q;
         end
         ST_MUL: begin
            alu_A   = acc_q;
            alu_B   = a_q;
            alu_sel = SEL_ADD;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         a_q           <= '0;
         b_q           <= '0;
         acc_q         <= '0;
         sel_q         <= '0;
         cin_q         <= 1'b0;
         id_q          <= 1'b0;
         cnt_q         <= '0;
         resp_valid    <= 1'b0;
         resp_id       <= 1'b0;
         resp_Y        <= '0;
         resp_Cout     <= 1'b0;
         resp_Negative <= 1'b0;
         resp_Zero     <= 1'b0;
         resp_Overflow <= 1'b0;
         resp_err      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  a_q   <= g_a;
                  b_q   <= g_b;
                  sel_q <= g_sel;
                  cin_q <= g_cin;
                  id_q  <= grant1;
                  acc_q <= '0;
                  cnt_q <= '0;
                  if (g_sel == SEL_MUL) begin
                     state_q <= ST_MUL;
                  end else if (is_legal_sel(g_sel)) begin
                     state_q <= ST_EXEC;
                  end else begin
                     state_q       <= ST_RESP;
                     resp_valid    <= 1'b1;
                     resp_id       <= grant1;
                     resp_err      <= 1'b1;
                     resp_Y        <= '0;
                     resp_Cout     <= 1'b0;
                     resp_Negative <= 1'b0;
                     resp_Zero     <= 1'b0;
                     resp_Overflow <= 1'b0;
                  end
               end
            end
            ST_EXEC: begin
               state_q       <= ST_RESP;
               resp_valid    <= 1'b1;
               resp_id       <= id_q;
               resp_err      <= 1'b0;
               resp_Y        <= alu_Y;
               resp_Cout     <= alu_Cout;
               resp_Negative <= alu_Negative;
               resp_Zero     <= alu_Zero;
               resp_Overflow <= alu_Overflow;
            end
            ST_MUL: begin
               acc_q <= acc_d;
               a_q   <= a_q << 1;
               b_q   <= b_q >> 1;
               cnt_q <= cnt_q + 5'd1;
               if (mul_done) begin
                  state_q       <= ST_RESP;
                  resp_valid    <= 1'b1;
                  resp_id       <= id_q;
                  resp_err      <= 1'b0;
                  resp_Y        <= acc_d;
                  resp_Cout     <= 1'b0;
                  resp_Negative <= acc_d[31];
                  resp_Zero     <= (acc_d == 32'd0);
                  resp_Overflow <= 1'b0;
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               resp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Directed bench for alu_rr_sequencer: behavioural ALU model, table of
// single-op vectors, plus arbitration, async-reset and no-early-exit sequences.
module tb_alu_rr_sequencer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        req0_valid, req1_valid, req0_Cin, req1_Cin;
   logic [31:0] req0_A, req0_B, req1_A, req1_B;
   logic [3:0]  req0_sel, req1_sel;

   logic        d0_r0, d0_r1, d0_rv, d0_rid, d0_rc, d0_rn, d0_rz, d0_rov, d0_rerr, d0_busy;
   logic [31:0] d0_ry, d0_aA, d0_aB, d0_yY;
   logic [3:0]  d0_aS;
   logic        d0_aC, d0_yC, d0_yN, d0_yZ, d0_yV;
   logic        d1_r0, d1_r1, d1_rv, d1_rid, d1_rc, d1_rn, d1_rz, d1_rov, d1_rerr, d1_busy;
   logic [31:0] d1_ry, d1_aA, d1_aB, d1_yY;
   logic [3:0]  d1_aS;
   logic        d1_aC, d1_yC, d1_yN, d1_yZ, d1_yV;

   function automatic logic [35:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] s, input logic c);
      logic [32:0] t;
      logic [31:0] y;
      logic co, ov;
      t = '0; y = '0; co = 1'b0; ov = 1'b0;
      case (s)
         4'b0000: y = a & b;
         4'b0001: y = a | b;
         4'b0010: y = a ^ b;
         4'b0110: begin
            t = {1'b0, a} + {1'b0, b} + {32'd0, c};
            y = t[31:0]; co = t[32];
            ov = (a[31] == b[31]) && (y[31] != a[31]);
         end
         4'b0111: begin
            t = {1'b0, a} + {1'b0, ~b} + 33'd1;
            y = t[31:0]; co = t[32];
            ov = (a[31] != b[31]) && (y[31] != a[31]);
         end
         4'b1010: y = a << b[4:0];
         4'b1011: y = a >> b[4:0];
         4'b1101: y = $signed(a) >>> b[4:0];
         default: y = '0;
      endcase
      return {co, y[31], (y == 32'd0), ov, y};
   endfunction

   always_comb {d0_yC, d0_yN, d0_yZ, d0_yV, d0_yY} = alu_f(d0_aA, d0_aB, d0_aS, d0_aC);
   always_comb {d1_yC, d1_yN, d1_yZ, d1_yV, d1_yY} = alu_f(d1_aA, d1_aB, d1_aS, d1_aC);

   alu_rr_sequencer #(.MUL_EARLY_EXIT(1'b1), .FIRST_PRIO(1'b0)) dut0 (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(d0_r0), .req0_A(req0_A), .req0_B(req0_B),
      .req0_sel(req0_sel), .req0_Cin(req0_Cin),
      .req1_valid(req1_valid), .req1_ready(d0_r1), .req1_A(req1_A), .req1_B(req1_B),
      .req1_sel(req1_sel), .req1_Cin(req1_Cin),
      .resp_valid(d0_rv), .resp_id(d0_rid), .resp_Y(d0_ry), .resp_Cout(d0_rc),
      .resp_Negative(d0_rn), .resp_Zero(d0_rz), .resp_Overflow(d0_rov), .resp_err(d0_rerr),
      .busy(d0_busy), .alu_A(d0_aA), .alu_B(d0_aB), .alu_sel(d0_aS), .alu_Cin(d0_aC),
      .alu_Y(d0_yY), .alu_Cout(d0_yC), .alu_Negative(d0_yN), .alu_Zero(d0_yZ),
      .alu_Overflow(d0_yV)
   );

   alu_rr_sequencer #(.MUL_EARLY_EXIT(1'b0), .FIRST_PRIO(1'b0)) dut1 (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(d1_r0), .req0_A(req0_A), .req0_B(req0_B),
      .req0_sel(req0_sel), .req0_Cin(req0_Cin),
      .req1_valid(req1_valid), .req1_ready(d1_r1), .req1_A(req1_A), .req1_B(req1_B),
      .req1_sel(req1_sel), .req1_Cin(req1_Cin),
      .resp_valid(d1_rv), .resp_id(d1_rid), .resp_Y(d1_ry), .resp_Cout(d1_rc),
      .resp_Negative(d1_rn), .resp_Zero(d1_rz), .resp_Overflow(d1_rov), .resp_err(d1_rerr),
      .busy(d1_busy), .alu_A(d1_aA), .alu_B(d1_aB), .alu_sel(d1_aS), .alu_Cin(d1_aC),
      .alu_Y(d1_yY), .alu_Cout(d1_yC), .alu_Negative(d1_yN), .alu_Zero(d1_yZ),
      .alu_Overflow(d1_yV)
   );

   typedef struct {
      logic        id;
      logic [3:0]  sel;
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic [31:0] y;
      logic [3:0]  flg;   // {Cout, Negative, Zero, Overflow}
      logic        err;
      int          lat;   // edges after the accept edge until resp_valid is seen
   } vec_t;

   vec_t vecs [12];

   int n_chk = 0;
   int n_fail = 0;

   logic [31:0] got_y;
   logic [3:0]  got_flg;
   logic        got_err, got_id;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_req(input logic id, input logic [3:0] s, input logic [31:0] a,
                          input logic [31:0] b, input logic c);
      if (id) begin
         req1_sel = s; req1_A = a; req1_B = b; req1_Cin = c; req1_valid = 1'b1;
      end else begin
         req0_sel = s; req0_A = a; req0_B = b; req0_Cin = c; req0_valid = 1'b1;
      end
   endtask

   // Waits for dut0 to accept one of the valid requests; returns #1 after the accept edge.
   task automatic accept_any(output logic id, output bit ok);
      ok = 1'b0;
      id = 1'b0;
      for (int k = 0; k < 100 && !ok; k++) begin
         @(negedge clk);
         if (d0_r0 | d0_r1) begin
            chk("arb_onehot", {63'd0, d0_r0 & d0_r1}, 64'd0);
            id = d0_r1;
            ok = 1'b1;
            @(posedge clk);
            #1;
         end
      end
      if (!ok) begin
         n_chk++; n_fail++;
         $display("FAIL accept_timeout: got no ready expected ready within 100 cycles");
      end
   endtask

   // Called #1 after the accept edge; counts edges until resp_valid, then checks the pulse.
   task automatic wait_resp(input string name, output int lat);
      bit done;
      done = 1'b0;
      lat = -1;
      for (int k = 0; k < 64 && !done; k++) begin
         if (d0_rv) begin
            lat = k;
            done = 1'b1;
            got_y = d0_ry; got_flg = {d0_rc, d0_rn, d0_rz, d0_rov};
            got_err = d0_rerr; got_id = d0_rid;
            chk({name, "_alu_idle"}, {d0_aA, d0_aB[27:0], d0_aS, d0_aC},
                64'd0);
            @(posedge clk); #1;
            chk({name, "_pulse"}, {63'd0, d0_rv}, 64'd0);
         end else begin
            @(posedge clk); #1;
         end
      end
      if (!done) begin
         n_chk++; n_fail++;
         $display("FAIL %s_resp_timeout: got no resp_valid expected one within 64 cycles", name);
      end
   endtask

   initial begin
      logic gid;
      bit   ok;
      int   lat, lat0, lat1;
      logic [31:0] y0, y1;
      logic z0, z1;
      int   npulse;
      logic exp_ids [7];

      vecs[0]  = '{1'b0, 4'b0110, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 4'b0101, 1'b0, 1};
      vecs[1]  = '{1'b1, 4'b1001, 32'h00000007, 32'h00000006, 1'b0, 32'h0000002A, 4'b0000, 1'b0, 3};
      vecs[2]  = '{1'b1, 4'b1001, 32'h00000007, 32'h00000000, 1'b0, 32'h00000000, 4'b0010, 1'b0, 1};
      vecs[3]  = '{1'b0, 4'b1111, 32'h12345678, 32'h9ABCDEF0, 1'b1, 32'h00000000, 4'b0000, 1'b1, 0};
      vecs[4]  = '{1'b0, 4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'hF000F000, 4'b0100, 1'b0, 1};
      vecs[5]  = '{1'b1, 4'b0110, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 4'b1010, 1'b0, 1};
      vecs[6]  = '{1'b0, 4'b0110, 32'h00000005, 32'h00000003, 1'b1, 32'h00000009, 4'b0000, 1'b0, 1};
      vecs[7]  = '{1'b1, 4'b0111, 32'h00000003, 32'h00000005, 1'b0, 32'hFFFFFFFE, 4'b0100, 1'b0, 1};
      vecs[8]  = '{1'b0, 4'b1001, 32'hFFFFFFFF, 32'h00000003, 1'b0, 32'hFFFFFFFD, 4'b0100, 1'b0, 2};
      vecs[9]  = '{1'b1, 4'b1110, 32'h00000001, 32'h00000001, 1'b0, 32'h00000000, 4'b0000, 1'b1, 0};
      vecs[10] = '{1'b0, 4'b1001, 32'h00000003, 32'h80000000, 1'b0, 32'h80000000, 4'b0100, 1'b0, 32};
      vecs[11] = '{1'b1, 4'b1010, 32'h00000001, 32'h00000004, 1'b0, 32'h00000010, 4'b0000, 1'b0, 1};

      exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

      rst = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_A = '0; req0_B = '0; req0_sel = '0; req0_Cin = 1'b0;
      req1_A = '0; req1_B = '0; req1_sel = '0; req1_Cin = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      chk("reset_resp", {d0_rv, d0_rid, d0_rc, d0_rn, d0_rz, d0_rov, d0_rerr, d0_busy, d0_ry},
          64'd0);
      chk("reset_alu", {d0_aA, d0_aB[27:0], d0_aS, d0_aC}, 64'd0);
      chk("reset_ready", {62'd0, d0_r0, d0_r1}, 64'd0);

      // Contention: both valid continuously, then req1 alone, then both again.
      set_req(1'b0, 4'b0110, 32'd1, 32'd1, 1'b0);
      set_req(1'b1, 4'b0110, 32'd10, 32'd10, 1'b0);
      for (int i = 0; i < 7; i++) begin
         if (i == 4) req0_valid = 1'b0;
         if (i == 6) req0_valid = 1'b1;
         accept_any(gid, ok);
         chk($sformatf("arb%0d_grant", i), {63'd0, gid}, {63'd0, exp_ids[i]});
         wait_resp($sformatf("arb%0d", i), lat);
         chk($sformatf("arb%0d_resp_id", i), {63'd0, got_id}, {63'd0, exp_ids[i]});
         chk($sformatf("arb%0d_y", i), {32'd0, got_y}, exp_ids[i] ? 64'd20 : 64'd2);
         $display("arb %0d: grant=%0d resp_id=%0d Y=%0d lat=%0d", i, gid, got_id, got_y, lat);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;

      for (int i = 0; i < 12; i++) begin
         set_req(vecs[i].id, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].cin);
         accept_any(gid, ok);
         req0_valid = 1'b0; req1_valid = 1'b0;
         chk($sformatf("v%0d_grant", i), {63'd0, gid}, {63'd0, vecs[i].id});
         wait_resp($sformatf("v%0d", i), lat);
         chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
         chk($sformatf("v%0d_y", i), {32'd0, got_y}, {32'd0, vecs[i].y});
         chk($sformatf("v%0d_flags", i), {60'd0, got_flg}, {60'd0, vecs[i].flg});
         chk($sformatf("v%0d_err", i), {63'd0, got_err}, {63'd0, vecs[i].err});
         chk($sformatf("v%0d_id", i), {63'd0, got_id}, {63'd0, vecs[i].id});
         $display("vec %0d: sel=%b A=%h B=%h Y=%h flags=%b err=%0d lat=%0d", i, vecs[i].sel,
                  vecs[i].a, vecs[i].b, got_y, got_flg, got_err, lat);
      end

      // Async reset in the middle of a long MUL: dropped op, outputs clear at once.
      set_req(1'b0, 4'b1001, 32'd3, 32'hFFFFFFFF, 1'b0);
      accept_any(gid, ok);
      req0_valid = 1'b0;
      repeat (9) @(posedge clk);
      #3;
      chk("mul_midrun_busy", {63'd0, d0_busy}, 64'd1);
      rst = 1'b1;
      #1;
      chk("async_rst_resp", {d0_rv, d0_rc, d0_rn, d0_rz, d0_rov, d0_rerr, d0_busy, d0_ry},
          64'd0);
      chk("async_rst_alu", {d0_aA, d0_aB[27:0], d0_aS, d0_aC}, 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      npulse = 0;
      for (int k = 0; k < 40; k++) begin
         if (d0_rv) npulse++;
         @(posedge clk); #1;
      end
      chk("dropped_op_no_resp", 64'(npulse), 64'd0);
      $display("reset mid-MUL: responses after release=%0d", npulse);
      set_req(1'b1, 4'b0110, 32'd2, 32'd2, 1'b0);
      accept_any(gid, ok);
      req1_valid = 1'b0;
      wait_resp("post_rst", lat);
      chk("post_rst_y", {32'd0, got_y}, 64'd4);
      chk("post_rst_lat", 64'(lat), 64'd1);
      chk("post_rst_id", {63'd0, got_id}, 64'd1);
      $display("post-reset ADD: Y=%0d lat=%0d id=%0d", got_y, lat, got_id);

      // Same MUL on both instances: early exit vs. full 32 steps.
      set_req(1'b0, 4'b1001, 32'h00010000, 32'h00010000, 1'b0);
      @(negedge clk);
      chk("noee_both_ready", {62'd0, d0_r0, d1_r0}, 64'd3);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      lat0 = -1; lat1 = -1; y0 = '1; y1 = '1; z0 = 1'b0; z1 = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (d0_rv && lat0 < 0) begin lat0 = k; y0 = d0_ry; z0 = d0_rz; end
         if (d1_rv && lat1 < 0) begin lat1 = k; y1 = d1_ry; z1 = d1_rz; end
         @(posedge clk); #1;
      end
      chk("ee_mul_lat", 64'(lat0), 64'd17);
      chk("ee_mul_y", {32'd0, y0}, 64'd0);
      chk("ee_mul_zero", {63'd0, z0}, 64'd1);
      chk("noee_mul_lat", 64'(lat1), 64'd32);
      chk("noee_mul_y", {32'd0, y1}, 64'd0);
      chk("noee_mul_zero", {63'd0, z1}, 64'd1);
      $display("MUL 0x10000*0x10000: early-exit lat=%0d Y=%h, full lat=%0d Y=%h",
               lat0, y0, lat1, y1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
